// File: rtl/matmul_sequencer_pkg.sv
// Shared types for the 3x3 matmul sequencer: state codes,
// index widths and the {row,col} select packing used by the decoders.
package matmul_sequencer_pkg;

  localparam int IDX_W = 2;
  localparam int SEL_W = 2 * IDX_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAC   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    MAC   = ST_MAC,
    WAIT  = ST_WAIT,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic sel_t sel_pack(
    input idx_t row,
    input idx_t col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Host control plus operand/MAC/result strobes of the sequencer.
// master is the sequencer side, slave the host/datapath side.
interface matmul_sequencer_if;
  import matmul_sequencer_pkg::*;

  logic start;
  logic abort;
  logic hold;
  logic busy;
  logic done;
  sel_t a_sel;
  sel_t b_sel;
  logic rd_en;
  logic mac_en;
  logic mac_first;
  sel_t c_sel;
  logic c_wr;

  modport master (
    input  start, abort, hold,
    output busy, done, a_sel, b_sel,
    output rd_en, mac_en, mac_first,
    output c_sel, c_wr
  );

  modport slave (
    output start, abort, hold,
    input  busy, done, a_sel, b_sel,
    input  rd_en, mac_en, mac_first,
    input  c_sel, c_wr
  );

endinterface

// File: rtl/matmul_sequencer_idx_counter.sv
// Nested k / j,i index counter; each field wraps at DIM-1.
// step_ij walks j first and carries into i.
module mm_idx_counter
  import matmul_sequencer_pkg::*;
#(
  parameter int DIM = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_k,
  input  logic step_ij,
  input  logic clr,
  output idx_t i,
  output idx_t j,
  output idx_t k,
  output logic k_last,
  output logic ij_last
);

  localparam idx_t LAST = IDX_W'(DIM - 1);

  logic j_last;
  logic i_last;

  assign k_last  = (k == LAST);
  assign j_last  = (j == LAST);
  assign i_last  = (i == LAST);
  assign ij_last = i_last && j_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (step_k)
        k <= k_last ? '0 : k + 1'b1;
      if (step_ij) begin
        if (j_last) begin
          j <= '0;
          i <= i_last ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Matmul control sequencer: walks C[i][j], issues DIM MAC steps,
// waits MAC_LAT cycles, then writes the result element.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int DIM     = 3,
  parameter int MAC_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  matmul_sequencer_if.master bus
);

  localparam bit   HAS_WAIT = (MAC_LAT > 0);
  localparam idx_t W_LAST   =
    IDX_W'(HAS_WAIT ? MAC_LAT - 1 : 0);

  state_t state;
  state_t state_n;
  idx_t   i, j, k, w;
  logic   k_last, ij_last;
  logic   step_k, step_ij, clr;
  logic   w_clr, w_inc;
  logic   run;
  logic   rd_en, mac_en, mac_first;
  logic   c_wr, done;

  mm_idx_counter #(.DIM(DIM)) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_k  (step_k),
    .step_ij (step_ij),
    .clr     (clr),
    .i       (i),
    .j       (j),
    .k       (k),
    .k_last  (k_last),
    .ij_last (ij_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w     <= '0;
    end else begin
      state <= state_n;
      if (w_clr)
        w <= '0;
      else if (w_inc)
        w <= w + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    step_k  = 1'b0;
    step_ij = 1'b0;
    clr     = 1'b0;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      clr     = 1'b1;
      w_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort)
            state_n = MAC;
        end
        MAC: begin
          if (!bus.hold) begin
            step_k = 1'b1;
            if (k_last) begin
              w_clr   = 1'b1;
              state_n = HAS_WAIT ? WAIT : WRITE;
            end
          end
        end
        WAIT: begin
          if (!bus.hold) begin
            if (w == W_LAST) begin
              w_clr   = 1'b1;
              state_n = WRITE;
            end else begin
              w_inc = 1'b1;
            end
          end
        end
        WRITE: begin
          if (!bus.hold) begin
            if (ij_last) begin
              state_n = DONE;
            end else begin
              step_ij = 1'b1;
              state_n = MAC;
            end
          end
        end
        DONE: begin
          state_n = IDLE;
          clr     = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // hold/abort gate the strobes combinationally; selects stay registered
  assign run = !bus.hold && !bus.abort;

  always_comb begin
    rd_en     = 1'b0;
    mac_en    = 1'b0;
    mac_first = 1'b0;
    c_wr      = 1'b0;
    done      = 1'b0;
    unique case (1'b1)
      (state == MAC): begin
        rd_en     = run;
        mac_en    = run;
        mac_first = run && (k == '0);
      end
      (state == WRITE): c_wr = run;
      (state == DONE):  done = !bus.abort;
      default: ;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.rd_en     = rd_en;
  assign bus.mac_en    = mac_en;
  assign bus.mac_first = mac_first;
  assign bus.c_wr      = c_wr;
  assign bus.a_sel     = sel_pack(i, k);
  assign bus.b_sel     = sel_pack(k, j);
  assign bus.c_sel     = sel_pack(i, j);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: default 3x3/LAT1 and a
// 2x2/LAT0 instance, with hold, abort, start-spam and reset cases.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_sequencer_if bus0 ();
  matmul_sequencer_if bus1 ();

  matmul_sequencer #(.DIM(3), .MAC_LAT(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  matmul_sequencer #(.DIM(2), .MAC_LAT(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic sel = 1'b0;
  logic t_start = 1'b0;
  logic t_abort = 1'b0;
  logic t_hold = 1'b0;

  assign bus0.start = !sel && t_start;
  assign bus0.abort = !sel && t_abort;
  assign bus0.hold  = !sel && t_hold;
  assign bus1.start = sel && t_start;
  assign bus1.abort = sel && t_abort;
  assign bus1.hold  = sel && t_hold;

  logic       o_busy, o_done, o_rd_en, o_mac_en;
  logic       o_mac_first, o_c_wr;
  logic [3:0] o_a_sel, o_b_sel, o_c_sel;

  always_comb begin
    if (sel) begin
      o_busy      = bus1.busy;
      o_done      = bus1.done;
      o_rd_en     = bus1.rd_en;
      o_mac_en    = bus1.mac_en;
      o_mac_first = bus1.mac_first;
      o_c_wr      = bus1.c_wr;
      o_a_sel     = bus1.a_sel;
      o_b_sel     = bus1.b_sel;
      o_c_sel     = bus1.c_sel;
    end else begin
      o_busy      = bus0.busy;
      o_done      = bus0.done;
      o_rd_en     = bus0.rd_en;
      o_mac_en    = bus0.mac_en;
      o_mac_first = bus0.mac_first;
      o_c_wr      = bus0.c_wr;
      o_a_sel     = bus0.a_sel;
      o_b_sel     = bus0.b_sel;
      o_c_sel     = bus0.c_sel;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] a_log [0:127];
  logic [3:0] b_log [0:127];
  logic [3:0] c_log [0:127];
  logic [3:0] stb_log [0:127];
  int         wr_sel [0:15];
  int         wr_cyc [0:15];
  int         n_wr;
  int         done_cyc;
  int         idle_cyc;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // cycle n begins at edge n-1; start is sampled at edge 0
  task automatic run(
    input int maxc,
    input int hold_at,
    input int hold_len,
    input int abort_at,
    input bit start_all
  );
    bit fin;
    fin = 1'b0;
    n_wr = 0;
    done_cyc = 0;
    idle_cyc = 0;
    @(posedge clk); #1;
    t_start = 1'b1;
    t_hold  = 1'b0;
    t_abort = 1'b0;
    for (int n = 1; n <= maxc && !fin; n++) begin
      @(posedge clk); #1;
      t_start = start_all;
      t_hold  = (n >= hold_at) && (n < hold_at + hold_len);
      t_abort = (n == abort_at);
      @(negedge clk);
      a_log[n]   = o_a_sel;
      b_log[n]   = o_b_sel;
      c_log[n]   = o_c_sel;
      stb_log[n] = {o_rd_en, o_mac_en, o_mac_first, o_c_wr};
      if (o_c_wr && n_wr < 16) begin
        wr_sel[n_wr] = int'(o_c_sel);
        wr_cyc[n_wr] = n;
        n_wr++;
      end
      if (o_done) begin
        done_cyc = n;
        fin = 1'b1;
      end else if (!o_busy) begin
        idle_cyc = n;
        fin = 1'b1;
      end
    end
    @(posedge clk); #1;
    t_start = 1'b0;
    t_hold  = 1'b0;
    t_abort = 1'b0;
    @(negedge clk);
    if (!fin)
      check("run_timeout", 0, 1);
    if (done_cyc > 0)
      check("idle_after_done", int'(o_busy), 0);
  endtask

  int exp3 [0:8] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int exp2 [0:3] = '{0, 1, 4, 5};
  int bad;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_done", int'(bus0.done), 0);
    check("rst_strobes", int'({bus0.rd_en, bus0.mac_en,
          bus0.mac_first, bus0.c_wr}), 0);
    check("rst_sel", int'({bus0.a_sel, bus0.b_sel,
          bus0.c_sel}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(o_busy), 0);

    // default 3x3, MAC_LAT=1
    run(80, 0, 0, 0, 1'b0);
    check("d_nwr", n_wr, 9);
    for (int e = 0; e < 9; e++)
      check($sformatf("d_csel%0d", e), wr_sel[e], exp3[e]);
    check("d_done", done_cyc, 46);
    check("d_last_wr", wr_cyc[8], 45);
    for (int n = 1; n <= 3; n++) begin
      check($sformatf("d_asel%0d", n), int'(a_log[n]), n - 1);
      check($sformatf("d_bsel%0d", n), int'(b_log[n]),
            4 * (n - 1));
    end
    check("d_stb1", int'(stb_log[1]), 14);
    check("d_stb2", int'(stb_log[2]), 12);
    check("d_stb_wait", int'(stb_log[4]), 0);
    check("d_stb_write", int'(stb_log[5]), 1);

    // 2x2, MAC_LAT=0
    sel = 1'b1;
    run(40, 0, 0, 0, 1'b0);
    check("s_nwr", n_wr, 4);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("s_csel%0d", e), wr_sel[e], exp2[e]);
      check($sformatf("s_wrcyc%0d", e), wr_cyc[e], 3 * e + 3);
    end
    check("s_done", done_cyc, 13);
    bad = 0;
    for (int n = 1; n <= 13; n++)
      if (a_log[n][3] || a_log[n][1] || b_log[n][3] ||
          b_log[n][1] || c_log[n][3] || c_log[n][1])
        bad++;
    check("s_field_range", bad, 0);
    sel = 1'b0;

    // hold 4 cycles in second MAC cycle of element (1,1)
    run(80, 22, 4, 0, 1'b0);
    for (int n = 22; n <= 25; n++) begin
      check($sformatf("h_stb%0d", n), int'(stb_log[n]), 0);
      check($sformatf("h_asel%0d", n), int'(a_log[n]), 5);
      check($sformatf("h_bsel%0d", n), int'(b_log[n]), 5);
    end
    check("h_resume_stb", int'(stb_log[26]), 12);
    check("h_resume_asel", int'(a_log[26]), 5);
    check("h_nwr", n_wr, 9);
    check("h_done", done_cyc, 50);

    // abort in WAIT of element (0,2)
    run(80, 0, 0, 14, 1'b0);
    check("a_stb14", int'(stb_log[14]), 0);
    check("a_idle", idle_cyc, 15);
    check("a_nwr", n_wr, 2);
    check("a_no_done", done_cyc, 0);
    run(80, 0, 0, 0, 1'b0);
    check("a_restart_csel", wr_sel[0], 0);
    check("a_restart_first", int'(stb_log[1]), 14);
    check("a_restart_nwr", n_wr, 9);
    check("a_restart_done", done_cyc, 46);

    // start held high through the run
    run(80, 0, 0, 0, 1'b1);
    check("r_nwr", n_wr, 9);
    check("r_done", done_cyc, 46);

    // asynchronous reset mid-run
    @(posedge clk); #1;
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check("x_pre_asel", int'(o_a_sel), 1);
    check("x_pre_bsel", int'(o_b_sel), 6);
    rst_n = 1'b0;
    #1;
    check("x_busy", int'(o_busy), 0);
    check("x_strobes", int'({o_rd_en, o_mac_en,
          o_mac_first, o_c_wr, o_done}), 0);
    check("x_sel", int'({o_a_sel, o_b_sel, o_c_sel}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("x_idle", int'(o_busy), 0);
    check("x_idle_sel", int'({o_a_sel, o_c_sel}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
